minitb_ahb_arbiter: RTL and testbench
=====================================

// Module: minitb_ahb_arbiter
// PURPOSE
//  Shares one AHB-lite slave between NUM_MASTERS minitb AHB master BFMs and RTL masters.
//  - Round-robin arbitration of address phases.
//  - Tracks the data-phase owner and muxes its hwdata onto the slave bus.
//  - Stalls losing masters through their own hready.
//  - Sits between the master-side interfaces and a single slave/DUT.
// PARAMETERS
//  NUM_MASTERS  2   number of requesting masters (>=2)
//  addrWidth    8   haddr width
//  dataWidth    32  hwdata/hrdata width
//  IDX_W        $clog2(NUM_MASTERS)  master index width (localparam)
// PORTS
//  hclk      in   1                        bus clock, all state on posedge
//  hreset    in   1                        synchronous, active-high reset
//  m_htrans  in   2*NUM_MASTERS            per-master htrans, master i at [2i+:2]
//  m_haddr   in   addrWidth*NUM_MASTERS    per-master address
//  m_hwrite  in   NUM_MASTERS              per-master write flag
//  m_hwdata  in   dataWidth*NUM_MASTERS    per-master write data
//  m_hready  out  NUM_MASTERS              per-master ready/stall
//  m_hrdata  out  dataWidth                read data, broadcast to all masters
//  s_htrans  out  2                        slave-side htrans
//  s_haddr   out  addrWidth                slave-side address
//  s_hwrite  out  1                        slave-side write flag
//  s_hwdata  out  dataWidth                slave-side write data
//  s_hready  in   1                        slave ready
//  s_hrdata  in   dataWidth                slave read data
// BEHAVIOUR
//  - Request: req[i] = (m_htrans[i] == NONSEQ). Any other htrans value is idle.
//  - State regs:
//    - last_q: last granted index. Reset value NUM_MASTERS-1, so master 0 wins first.
//    - hold_q, held_q: address-phase freeze.
//    - dv_q, own_q: data-phase valid and owner.
//  - Selection:
//    - hold_q=1: sel=held_q.
//    - Otherwise: first requester scanning last_q+1 .. last_q+NUM_MASTERS, modulo NUM_MASTERS (wrap).
//    - gnt = hold_q | req[sel].
//  - Slave address phase (combinational):
//    - gnt=1: s_htrans/s_haddr/s_hwrite come from master sel.
//    - gnt=0: s_htrans=IDLE, s_haddr=0, s_hwrite=0.
//  - s_hwdata = m_hwdata[own_q] when dv_q=1, else 0. m_hrdata = s_hrdata, zero latency.
//  - m_hready[i]:
//    - s_hready if i == own_q with dv_q=1.
//    - s_hready if i == sel with gnt=1.
//    - 0 if req[i]=1 and i is not granted (stalls the loser; it holds its address).
//    - 1 otherwise (idle master).
//  - Posedge with s_hready=1:
//    - dv_q <= gnt; own_q <= sel; hold_q <= 0.
//    - If gnt: last_q <= sel.
//  - Posedge with s_hready=0:
//    - If gnt: hold_q <= 1, held_q <= sel. The address stays stable through wait states even if new requests arrive.
//    - dv_q/own_q unchanged.
//  - Simultaneous events:
//    - Owner of the data phase may also win the next address phase (pipelined back-to-back, one transfer per cycle).
//    - A sole requester wins every cycle; round-robin only rotates among active requesters.
//  - Reset (sync, any cycle, including mid data phase):
//    - dv_q=0, hold_q=0, last_q=NUM_MASTERS-1.
//    - The in-flight transfer is abandoned with no completion. The slave sees IDLE from the next cycle if no requests.
//    - Outputs after reset with no requests: s_htrans=IDLE, s_haddr=0, s_hwrite=0, s_hwdata=0, m_hready all 1.
//  - No hresp/split/retry/lock/bursts. SEQ/BUSY are treated as idle.
// STRUCTURE
//  - minitb_ahb_pkg: IDLE=2'b00, NONSEQ=2'b10, typedef logic [1:0] htrans_t. Shared with the master BFM.
//  - Sub-module minitb_rr_arbiter #(N): req, last index -> sel index, any.
//  - Top owns hold/data-phase regs and muxes.
// TESTING
//  - Reset: hreset=1 for 2 cycles, no requests -> s_htrans=IDLE, s_hwdata=0, m_hready=2'b11.
//  - M0 writes 0x10 <- 0xDEADBEEF, s_hready=1 -> cycle 1: s_htrans=NONSEQ, s_haddr=0x10, s_hwrite=1;
//    cycle 2: s_hwdata=0xDEADBEEF, m_hready[0]=1.
//  - M0 and M1 issue NONSEQ in the same cycle after reset -> M0 granted, m_hready[1]=0;
//    next cycle s_haddr=M1 addr. Repeated contention alternates 0,1,0,1.
//  - M0 write in data phase while M1 read of 0x20 is on the bus, s_hready=0 for 2 cycles:
//    - s_haddr holds 0x20 and s_hwdata holds M0 data; m_hready=2'b00.
//    - Then s_hready=1 completes both stages.
//  - M0 issues back-to-back reads 0x04, 0x08 with M1 idle, slave returns 0x11, 0x22 -> one transfer per cycle;
//    M0 samples 0x11 then 0x22.
//  - hreset pulsed during M1 data phase -> next cycle: dv_q=0, s_hwdata=0, s_htrans=IDLE; following grant goes to M0.

Source files
------------

// File: rtl/minitb_ahb_pkg.sv
// ---------------------------------------------------------------------------
// minitb_ahb_pkg
// Shared AHB-lite encodings for the minitb arbiter and the master BFMs.
//   htrans_t   2-bit transfer type
//   IDLE       no transfer
//   NONSEQ     single transfer; the only encoding treated as a request
//   is_nonseq  helper: true when a master is requesting an address phase
// ---------------------------------------------------------------------------
package minitb_ahb_pkg;

    typedef logic [1:0] htrans_t;

    localparam htrans_t IDLE   = 2'b00;
    localparam htrans_t NONSEQ = 2'b10;

    // SEQ and BUSY are deliberately not requests: bursts are not supported.
    function automatic logic is_nonseq(input htrans_t t);
        return t == NONSEQ;
    endfunction

endpackage

// File: rtl/minitb_ahb_arbiter_if.sv
// ---------------------------------------------------------------------------
// minitb_ahb_arbiter_if
// Bundles the master-side (per-master, packed) and slave-side AHB-lite
// signals around the arbiter.
//   m_htrans/m_haddr/m_hwrite/m_hwdata  master i at slice [i*W +: W]
//   m_hready                            per-master ready/stall
//   m_hrdata                            read data broadcast to all masters
//   s_*                                 single shared slave bus
// Modports:
//   master   the requesting masters
//   slave    the shared slave
//   arbiter  the arbiter sitting between them
// ---------------------------------------------------------------------------
interface minitb_ahb_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int addrWidth   = 8,
    parameter int dataWidth   = 32
);

    logic [2*NUM_MASTERS-1:0]         m_htrans;
    logic [addrWidth*NUM_MASTERS-1:0] m_haddr;
    logic [NUM_MASTERS-1:0]           m_hwrite;
    logic [dataWidth*NUM_MASTERS-1:0] m_hwdata;
    logic [NUM_MASTERS-1:0]           m_hready;
    logic [dataWidth-1:0]             m_hrdata;

    logic [1:0]                       s_htrans;
    logic [addrWidth-1:0]             s_haddr;
    logic                             s_hwrite;
    logic [dataWidth-1:0]             s_hwdata;
    logic                             s_hready;
    logic [dataWidth-1:0]             s_hrdata;

    modport master (
        output m_htrans, m_haddr, m_hwrite, m_hwdata,
        input  m_hready, m_hrdata
    );

    modport slave (
        input  s_htrans, s_haddr, s_hwrite, s_hwdata,
        output s_hready, s_hrdata
    );

    modport arbiter (
        input  m_htrans, m_haddr, m_hwrite, m_hwdata, s_hready, s_hrdata,
        output m_hready, m_hrdata, s_htrans, s_haddr, s_hwrite, s_hwdata
    );

endinterface

// File: rtl/minitb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// minitb_rr_arbiter
// Combinational round-robin selector.
//   req   per-master request vector
//   last  index granted most recently
//   sel   first requester after last (wrapping); 0 when none
//   any   at least one requester
// ---------------------------------------------------------------------------
module minitb_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] sel,
    output logic             any
);

    // Scan from the farthest candidate towards the nearest so the last hit
    // written is the closest requester after 'last'; avoids a loop break.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        sel = '0;
        any = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                sel = IDX_W'((int'(last) + k) % N);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/minitb_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// minitb_ahb_arbiter
// Shares one AHB-lite slave between NUM_MASTERS masters.
//   hclk    bus clock, all state on posedge
//   hreset  synchronous, active-high reset
//   bus     minitb_ahb_arbiter_if.arbiter (master side + slave side)
// Address phases are granted round-robin; the granted address is frozen
// through slave wait states. The data-phase owner's hwdata is muxed onto
// the slave; hrdata is broadcast with zero latency. Losing requesters are
// stalled through their own m_hready.
// ---------------------------------------------------------------------------
module minitb_ahb_arbiter
    import minitb_ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int addrWidth   = 8,
    parameter int dataWidth   = 32
) (
    input  logic                 hclk,
    input  logic                 hreset,
    minitb_ahb_arbiter_if.arbiter bus
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    typedef logic [IDX_W-1:0] idx_t;

    logic [NUM_MASTERS-1:0] req;
    idx_t                   rr_sel;
    logic                   rr_any;
    idx_t                   sel;
    logic                   gnt;

    idx_t last_q, last_d;
    idx_t held_q, held_d;
    idx_t own_q,  own_d;
    logic hold_q, hold_d;
    logic dv_q,   dv_d;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            req[i] = is_nonseq(bus.m_htrans[2*i +: 2]);
        end
    end

    minitb_rr_arbiter #(.N(NUM_MASTERS)) u_rr (
        .req  (req),
        .last (last_q),
        .sel  (rr_sel),
        .any  (rr_any)
    );

    // A frozen address phase keeps its grant regardless of new requests.
    assign sel = hold_q ? held_q : rr_sel;
    assign gnt = hold_q | rr_any;

    // Address phase to the slave.
    always_comb begin
        bus.s_htrans = IDLE;
        bus.s_haddr  = '0;
        bus.s_hwrite = 1'b0;
        if (gnt) begin
            bus.s_htrans = bus.m_htrans[2*int'(sel) +: 2];
            bus.s_haddr  = bus.m_haddr[addrWidth*int'(sel) +: addrWidth];
            bus.s_hwrite = bus.m_hwrite[int'(sel)];
        end
    end

    // Data phase.
    assign bus.s_hwdata = dv_q ? bus.m_hwdata[dataWidth*int'(own_q) +: dataWidth]
                               : '0;
    assign bus.m_hrdata = bus.s_hrdata;

    // Data-phase owner and address-phase winner follow the slave; a
    // requester that lost arbitration is stalled; idle masters see ready.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (dv_q && own_q == idx_t'(i)) begin
                bus.m_hready[i] = bus.s_hready;
            end else if (gnt && sel == idx_t'(i)) begin
                bus.m_hready[i] = bus.s_hready;
            end else if (req[i]) begin
                bus.m_hready[i] = 1'b0;
            end else begin
                bus.m_hready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        held_d = held_q;
        own_d  = own_q;
        hold_d = hold_q;
        dv_d   = dv_q;
        if (bus.s_hready) begin
            dv_d   = gnt;
            own_d  = sel;
            hold_d = 1'b0;
            if (gnt) begin
                last_d = sel;
            end
        end else if (gnt) begin
            // Wait state: pin the address phase to the current winner.
            hold_d = 1'b1;
            held_d = sel;
        end
    end

    always_ff @(posedge hclk) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop
        // samples pre-edge values, independent of statement order.
        if (hreset) begin
            last_q <= idx_t'(NUM_MASTERS - 1);
            held_q <= '0;
            own_q  <= '0;
            hold_q <= 1'b0;
            dv_q   <= 1'b0;
        end else begin
            last_q <= last_d;
            held_q <= held_d;
            own_q  <= own_d;
            hold_q <= hold_d;
            dv_q   <= dv_d;
        end
    end

endmodule

// File: tb/tb_minitb_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_minitb_ahb_arbiter
// Self-checking bench for minitb_ahb_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model of
// the arbitration rules.
// ---------------------------------------------------------------------------
module tb_minitb_ahb_arbiter;
    import minitb_ahb_pkg::*;

    localparam int NM = 2;
    localparam int AW = 8;
    localparam int DW = 32;

    logic hclk;
    logic hreset;

    minitb_ahb_arbiter_if #(.NUM_MASTERS(NM), .addrWidth(AW), .dataWidth(DW)) bus ();

    minitb_ahb_arbiter #(.NUM_MASTERS(NM), .addrWidth(AW), .dataWidth(DW)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Per-master stimulus, packed onto the interface.
    logic [1:0]    htrans_a [NM];
    logic [AW-1:0] haddr_a  [NM];
    logic          hwrite_a [NM];
    logic [DW-1:0] hwdata_a [NM];

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            bus.m_htrans[2*i +: 2]  = htrans_a[i];
            bus.m_haddr[AW*i +: AW] = haddr_a[i];
            bus.m_hwrite[i]         = hwrite_a[i];
            bus.m_hwdata[DW*i +: DW] = hwdata_a[i];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Behavioural model: who was granted last, whether an address is frozen
    // by a wait state, and who owns the data phase (-1 meaning nobody).
    int  m_last;
    bit  m_hold;
    int  m_held;
    int  m_own;

    int            e_sel;
    bit            e_gnt;
    logic [1:0]    e_htrans;
    logic [AW-1:0] e_haddr;
    logic          e_hwrite;
    logic [DW-1:0] e_hwdata;
    logic [NM-1:0] e_hready;

    task automatic model_reset();
        m_last = NM - 1;
        m_hold = 0;
        m_held = 0;
        m_own  = -1;
    endtask

    task automatic compute_expect();
        int best_d;
        int d;
        e_sel = 0;
        e_gnt = 0;
        if (m_hold) begin
            e_sel = m_held;
            e_gnt = 1;
        end else begin
            // Winner = requester at the smallest rotational distance past m_last.
            best_d = NM;
            for (int i = 0; i < NM; i++) begin
                if (htrans_a[i] == NONSEQ) begin
                    d = (i - m_last - 1 + 2*NM) % NM;
                    if (d < best_d) begin
                        best_d = d;
                        e_sel  = i;
                        e_gnt  = 1;
                    end
                end
            end
        end
        e_htrans = e_gnt ? htrans_a[e_sel] : IDLE;
        e_haddr  = e_gnt ? haddr_a[e_sel]  : '0;
        e_hwrite = e_gnt ? hwrite_a[e_sel] : 1'b0;
        e_hwdata = (m_own >= 0) ? hwdata_a[m_own] : '0;
        for (int i = 0; i < NM; i++) begin
            if (m_own == i || (e_gnt && e_sel == i)) e_hready[i] = bus.s_hready;
            else if (htrans_a[i] == NONSEQ)          e_hready[i] = 1'b0;
            else                                     e_hready[i] = 1'b1;
        end
    endtask

    task automatic sample(input string tag);
        @(negedge hclk);
        compute_expect();
        check({tag, ".s_htrans"}, 64'(bus.s_htrans), 64'(e_htrans));
        check({tag, ".s_haddr"},  64'(bus.s_haddr),  64'(e_haddr));
        check({tag, ".s_hwrite"}, 64'(bus.s_hwrite), 64'(e_hwrite));
        check({tag, ".s_hwdata"}, 64'(bus.s_hwdata), 64'(e_hwdata));
        check({tag, ".m_hready"}, 64'(bus.m_hready), 64'(e_hready));
        check({tag, ".m_hrdata"}, 64'(bus.m_hrdata), 64'(bus.s_hrdata));
    endtask

    task automatic advance();
        if (hreset) begin
            model_reset();
        end else if (bus.s_hready) begin
            m_own  = e_gnt ? e_sel : -1;
            m_hold = 0;
            if (e_gnt) m_last = e_sel;
        end else if (e_gnt) begin
            m_hold = 1;
            m_held = e_sel;
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic set_m(input int i, input logic [1:0] t, input logic [AW-1:0] a, input logic w);
        htrans_a[i] = t;
        haddr_a[i]  = a;
        hwrite_a[i] = w;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NM; i++) set_m(i, IDLE, '0, 1'b0);
    endtask

    logic [AW-1:0] rr_addr [4];

    initial begin
        hreset       = 1'b1;
        bus.s_hready = 1'b1;
        bus.s_hrdata = '0;
        for (int i = 0; i < NM; i++) hwdata_a[i] = '0;
        idle_all();
        model_reset();
        repeat (2) @(posedge hclk);
        #1;
        hreset = 1'b0;

        // Reset state.
        sample("reset");
        check("reset.idle", 64'(bus.s_htrans), 64'(IDLE));
        check("reset.ready", 64'(bus.m_hready), 64'(2'b11));
        check("reset.hwdata", 64'(bus.s_hwdata), 64'd0);
        advance();

        // Single write from M0.
        set_m(0, NONSEQ, 8'h10, 1'b1);
        sample("wr_addr");
        check("wr_addr.haddr", 64'(bus.s_haddr), 64'h10);
        advance();
        set_m(0, IDLE, '0, 1'b0);
        hwdata_a[0] = 32'hDEADBEEF;
        sample("wr_data");
        check("wr_data.hwdata", 64'(bus.s_hwdata), 64'hDEADBEEF);
        check("wr_data.hready0", 64'(bus.m_hready[0]), 64'd1);
        advance();

        // Fresh reset, then sustained contention alternates M0, M1, M0, M1.
        hreset = 1'b1;
        sample("rst1");
        advance();
        hreset = 1'b0;
        set_m(0, NONSEQ, 8'h30, 1'b0);
        set_m(1, NONSEQ, 8'h40, 1'b0);
        rr_addr[0] = 8'h30; rr_addr[1] = 8'h40; rr_addr[2] = 8'h30; rr_addr[3] = 8'h40;
        for (int c = 0; c < 4; c++) begin
            sample("contend");
            check("contend.haddr", 64'(bus.s_haddr), 64'(rr_addr[c]));
            if (c == 0) check("contend.stall1", 64'(bus.m_hready), 64'(2'b01));
            advance();
        end
        idle_all();
        sample("drain0");
        advance();
        sample("drain1");
        advance();

        // M0 write in data phase while M1 read of 0x20 waits two cycles.
        set_m(0, NONSEQ, 8'h50, 1'b1);
        sample("ws_a");
        advance();
        set_m(0, IDLE, '0, 1'b0);
        hwdata_a[0] = 32'hCAFEF00D;
        set_m(1, NONSEQ, 8'h20, 1'b0);
        bus.s_hready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            sample("ws_wait");
            check("ws_wait.haddr", 64'(bus.s_haddr), 64'h20);
            check("ws_wait.hwdata", 64'(bus.s_hwdata), 64'hCAFEF00D);
            check("ws_wait.hready", 64'(bus.m_hready), 64'(2'b00));
            advance();
        end
        bus.s_hready = 1'b1;
        sample("ws_done");
        check("ws_done.hready", 64'(bus.m_hready), 64'(2'b11));
        advance();
        set_m(1, IDLE, '0, 1'b0);
        bus.s_hrdata = 32'h5555AAAA;
        sample("ws_rd");
        check("ws_rd.hrdata", 64'(bus.m_hrdata), 64'h5555AAAA);
        advance();

        // Back-to-back reads by M0 alone.
        set_m(0, NONSEQ, 8'h04, 1'b0);
        sample("b2b_0");
        advance();
        set_m(0, NONSEQ, 8'h08, 1'b0);
        bus.s_hrdata = 32'h11;
        sample("b2b_1");
        check("b2b_1.haddr", 64'(bus.s_haddr), 64'h08);
        check("b2b_1.hrdata", 64'(bus.m_hrdata), 64'h11);
        check("b2b_1.hready0", 64'(bus.m_hready[0]), 64'd1);
        advance();
        set_m(0, IDLE, '0, 1'b0);
        bus.s_hrdata = 32'h22;
        sample("b2b_2");
        check("b2b_2.hrdata", 64'(bus.m_hrdata), 64'h22);
        advance();

        // Reset during an M1 data phase.
        set_m(1, NONSEQ, 8'h70, 1'b0);
        sample("rst_mid_a");
        advance();
        set_m(1, IDLE, '0, 1'b0);
        hwdata_a[1] = 32'h0BADF00D;
        hreset = 1'b1;
        sample("rst_mid_b");
        advance();
        hreset = 1'b0;
        sample("rst_mid_c");
        check("rst_mid.hwdata", 64'(bus.s_hwdata), 64'd0);
        check("rst_mid.idle", 64'(bus.s_htrans), 64'(IDLE));
        advance();
        set_m(0, NONSEQ, 8'h30, 1'b0);
        set_m(1, NONSEQ, 8'h40, 1'b0);
        sample("rst_mid_d");
        check("rst_mid.m0_first", 64'(bus.s_haddr), 64'h30);
        advance();
        idle_all();
        sample("drain2");
        advance();

        // Randomized traffic: stalled masters hold their bus signals.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NM; i++) begin
                if (e_hready[i]) begin
                    if ($urandom_range(0, 9) < 5) htrans_a[i] = NONSEQ;
                    else                          htrans_a[i] = 2'($urandom_range(0, 3));
                    haddr_a[i]  = AW'($urandom);
                    hwrite_a[i] = 1'($urandom);
                    hwdata_a[i] = $urandom;
                end
            end
            bus.s_hready = ($urandom_range(0, 3) != 0);
            bus.s_hrdata = $urandom;
            hreset       = ($urandom_range(0, 49) == 0);
            sample("rand");
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
